addsub_result_buffer: RTL and testbench
=======================================

ADDSUB_RESULT_BUFFER -- requirements
Module: addsub_result_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the result width matching the upstream adder/subtractor.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, the upstream adder output is valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1, the buffer can accept an entry this cycle.
REQ-006 The block SHALL have ports in_result (input, WIDTH), in_overflow, in_carry and in_zero (input, 1 each), carrying the adder Result, Overflow, Carry and zero.
REQ-007 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), forming the downstream handshake.
REQ-008 The block SHALL have ports out_result (output, WIDTH), out_overflow, out_carry and out_zero (output, 1 each), carrying the head entry.
REQ-009 The block SHALL have port count, output, 2, the number of stored entries (0..2).
REQ-010 The block SHALL have port sticky_of, output, 1, set when any accepted entry had overflow.
REQ-011 The block SHALL have port sticky_clr, input, 1, which clears sticky_of and zero_err.
REQ-012 The block SHALL have port zero_err, output, 1, sticky; an accepted entry had in_zero inconsistent with in_result.

Function
REQ-013 The buffer SHALL be a 2-entry FIFO; each entry is {result, overflow, carry, zero}.
REQ-014 Push SHALL occur on in_valid && in_ready; pop SHALL occur on out_valid && out_ready.
REQ-015 in_ready SHALL equal (count != 2), registered-state only, with no combinational path from out_ready.
REQ-016 out_valid SHALL equal (count != 0), and out_* SHALL reflect the head entry; when empty, out_* SHALL be all zero.
REQ-017 Latency SHALL be 1 cycle: an entry pushed into an empty buffer at edge N is visible on out_* after edge N.
REQ-018 If push and pop coincide with count==1, count SHALL stay 1 and the new entry SHALL become head after the edge.
REQ-019 When count==2, in_ready SHALL be 0 and in_valid SHALL be ignored, even if a pop occurs in the same cycle.
REQ-020 When count==0, out_ready SHALL be ignored and count SHALL never underflow.
REQ-021 Order SHALL be strictly FIFO; the storage pointers wrap modulo 2.
REQ-022 sticky_of SHALL set on a push with in_overflow==1; if sticky_clr and that push coincide, set SHALL win.
REQ-023 zero_err SHALL set on a push where in_zero != (in_result == 0); it has the same clear and set-wins rule as sticky_of.
REQ-024 Data is captured unmodified; no arithmetic SHALL be performed on in_result.

Reset
REQ-025 While rst==1 at an edge, the block SHALL set count=0, out_valid=0, out_*=0, sticky_of=0 and zero_err=0.
REQ-026 in_ready SHALL be 0 during any cycle in which rst is high, and 1 in the first cycle after rst is released.
REQ-027 Reset mid-operation SHALL discard all stored entries, with no partial pop.

Structure
REQ-028 A shared package SHALL hold the DEPTH=2 constant, the default WIDTH, and the entry struct typedef.
REQ-029 Storage and pointers SHALL live in one sub-module, rb_fifo2; the sticky flags and zero check SHALL remain in the top level.

Verification
REQ-030 Check 1: push {0x02,of0,c0,z0} into an empty buffer with out_ready=0 -> next cycle out_valid=1, out_result=0x02, count=1.
REQ-031 Check 2: push 0x02, 0x00(z1), then 0xFF with out_ready=0 -> count=2, in_ready=0, 0xFF is dropped, and pops return 0x02 then 0x00.
REQ-032 Check 3: with count==1, drive push 0x7F and pop together -> count stays 1 and the head becomes 0x7F.
REQ-033 Check 4: push {0x80,of1} while sticky_clr=1 -> sticky_of=1; clear in the next cycle with no push -> sticky_of=0.
REQ-034 Check 5: push {0x00,z0} -> zero_err=1; push {0x01,z1} -> zero_err stays set.
REQ-035 Check 6: assert rst with count=2 -> next cycle count=0, out_valid=0, out_result=0x00, sticky flags 0.

Source files
------------

// File: rtl/addsub_result_buffer_pkg.sv
// Shared constants and entry layout for the adder/subtractor result buffer.
package addsub_result_buffer_pkg;

  localparam int DEPTH     = 2;
  localparam int DEF_WIDTH = 8;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic zero;
  } flags_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] result;
    flags_t               flags;
  } entry_t;

endpackage

// File: rtl/addsub_result_buffer_if.sv
// Valid/ready stream carrying one adder result plus its status flags.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface addsub_result_buffer_if
  import addsub_result_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry;
  logic             zero;

  modport src (output valid, result, overflow, carry, zero, input ready);
  modport snk (input valid, result, overflow, carry, zero, output ready);

endinterface

// File: rtl/addsub_result_buffer_rb_fifo2.sv
// Two-entry FIFO storage with 1-bit wrapping pointers; ready depends on stored state and rst only.
module rb_fifo2
  import addsub_result_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  addsub_result_buffer_if.snk        wr,
  addsub_result_buffer_if.src        rd,
  output logic [1:0]                 count_o
);

  logic [WIDTH-1:0] res_q [DEPTH];
  flags_t           flg_q [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push;
  logic             pop;

  always_comb begin
    wr.ready    = ~rst & (count_q != 2'(DEPTH));
    rd.valid    = (count_q != 2'd0);
    push        = wr.valid & wr.ready;
    pop         = rd.valid & rd.ready;
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    count_d     = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    // An empty buffer presents all-zero data rather than stale storage.
    rd.result   = '0;
    rd.overflow = 1'b0;
    rd.carry    = 1'b0;
    rd.zero     = 1'b0;
    if (rd.valid) begin
      rd.result   = res_q[rd_ptr_q];
      rd.overflow = flg_q[rd_ptr_q].overflow;
      rd.carry    = flg_q[rd_ptr_q].carry;
      rd.zero     = flg_q[rd_ptr_q].zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_q[wr_ptr_q] <= wr.result;
      flg_q[wr_ptr_q] <= '{overflow: wr.overflow, carry: wr.carry, zero: wr.zero};
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/addsub_result_buffer.sv
// Result buffer behind an adder/subtractor: 2-deep FIFO plus sticky overflow and zero-flag checks.
module addsub_result_buffer
  import addsub_result_buffer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_overflow,
  input  logic             in_carry,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_carry,
  output logic             out_zero,
  output logic [1:0]       count,
  output logic             sticky_of,
  input  logic             sticky_clr,
  output logic             zero_err
);

  addsub_result_buffer_if #(.WIDTH(WIDTH)) up_if ();
  addsub_result_buffer_if #(.WIDTH(WIDTH)) dn_if ();

  assign up_if.valid    = in_valid;
  assign up_if.result   = in_result;
  assign up_if.overflow = in_overflow;
  assign up_if.carry    = in_carry;
  assign up_if.zero     = in_zero;
  assign in_ready       = up_if.ready;

  assign dn_if.ready    = out_ready;
  assign out_valid      = dn_if.valid;
  assign out_result     = dn_if.result;
  assign out_overflow   = dn_if.overflow;
  assign out_carry      = dn_if.carry;
  assign out_zero       = dn_if.zero;

  rb_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (up_if),
    .rd      (dn_if),
    .count_o (count)
  );

  logic push_ok;
  logic zero_bad;
  logic sticky_of_q, sticky_of_d;
  logic zero_err_q, zero_err_d;

  // Only accepted entries may set the flags; a set on the same edge beats a clear.
  always_comb begin
    push_ok     = in_valid & in_ready;
    zero_bad    = in_zero != (in_result == '0);
    sticky_of_d = sticky_of_q;
    zero_err_d  = zero_err_q;
    if (push_ok && in_overflow) begin
      sticky_of_d = 1'b1;
    end else if (sticky_clr) begin
      sticky_of_d = 1'b0;
    end
    if (push_ok && zero_bad) begin
      zero_err_d = 1'b1;
    end else if (sticky_clr) begin
      zero_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_of_q <= 1'b0;
      zero_err_q  <= 1'b0;
    end else begin
      sticky_of_q <= sticky_of_d;
      zero_err_q  <= zero_err_d;
    end
  end

  assign sticky_of = sticky_of_q;
  assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_addsub_result_buffer.sv
// Bench for addsub_result_buffer: directed vector table followed by random traffic against a queue model.
module tb_addsub_result_buffer;
  import addsub_result_buffer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addsub_result_buffer_if #(.WIDTH(8)) up_if ();
  addsub_result_buffer_if #(.WIDTH(8)) dn_if ();

  logic       sticky_clr;
  logic       sticky_of;
  logic       zero_err;
  logic [1:0] count;

  addsub_result_buffer #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (up_if.valid),
    .in_ready     (up_if.ready),
    .in_result    (up_if.result),
    .in_overflow  (up_if.overflow),
    .in_carry     (up_if.carry),
    .in_zero      (up_if.zero),
    .out_valid    (dn_if.valid),
    .out_ready    (dn_if.ready),
    .out_result   (dn_if.result),
    .out_overflow (dn_if.overflow),
    .out_carry    (dn_if.carry),
    .out_zero     (dn_if.zero),
    .count        (count),
    .sticky_of    (sticky_of),
    .sticky_clr   (sticky_clr),
    .zero_err     (zero_err)
  );

  // ---------------- scoreboard / model ----------------
  int     n_vec = 0;
  int     n_err = 0;
  entry_t exp_q[$];
  logic   m_so = 1'b0;
  logic   m_ze = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic iv, input logic [7:0] res,
                       input logic [2:0] flg, input logic ordy, input logic sclr);
    rst            = r;
    up_if.valid    = iv;
    up_if.result   = res;
    up_if.overflow = flg[2];
    up_if.carry    = flg[1];
    up_if.zero     = flg[0];
    dn_if.ready    = ordy;
    sticky_clr     = sclr;
  endtask

  // Checks in_ready before the edge, clocks once, then advances the model.
  task automatic step();
    logic   push;
    logic   pop;
    logic   r;
    logic   clr;
    entry_t e;
    #1;
    chk("in_ready_pre", up_if.ready, (!rst && exp_q.size() < DEPTH));
    r        = rst;
    clr      = sticky_clr;
    push     = up_if.valid && !rst && (exp_q.size() < DEPTH);
    pop      = dn_if.ready && (exp_q.size() > 0);
    e.result = up_if.result;
    e.flags  = '{overflow: up_if.overflow, carry: up_if.carry, zero: up_if.zero};
    @(posedge clk);
    #1;
    if (r) begin
      exp_q.delete();
      m_so = 1'b0;
      m_ze = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(e);
      if (push && e.flags.overflow) m_so = 1'b1;
      else if (clr) m_so = 1'b0;
      if (push && (e.flags.zero != (e.result == 8'h00))) m_ze = 1'b1;
      else if (clr) m_ze = 1'b0;
    end
  endtask

  task automatic check_model();
    entry_t h;
    h = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk("count", count, exp_q.size());
    chk("out_valid", dn_if.valid, exp_q.size() > 0);
    chk("out_result", dn_if.result, h.result);
    chk("out_flags", {dn_if.overflow, dn_if.carry, dn_if.zero}, h.flags);
    chk("in_ready", up_if.ready, (!rst && exp_q.size() < DEPTH));
    chk("sticky_of", sticky_of, m_so);
    chk("zero_err", zero_err, m_ze);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] res;
    logic [2:0] flg;   // {overflow, carry, zero}
    logic       ordy;
    logic       sclr;
    logic [1:0] ecnt;
    logic       eov;
    logic [7:0] eres;
    logic [2:0] eflg;
    logic       erdy;
    logic       eso;
    logic       eze;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    //         rst iv res    flg     ordy sclr | cnt  ov res    flg     rdy so ze
    vecs[0]  = '{1, 0, 8'h00, 3'b000, 0, 0, 2'd0, 0, 8'h00, 3'b000, 0, 0, 0};
    vecs[1]  = '{0, 0, 8'h00, 3'b000, 0, 0, 2'd0, 0, 8'h00, 3'b000, 1, 0, 0};
    vecs[2]  = '{0, 1, 8'h02, 3'b000, 0, 0, 2'd1, 1, 8'h02, 3'b000, 1, 0, 0};
    vecs[3]  = '{0, 1, 8'h00, 3'b001, 0, 0, 2'd2, 1, 8'h02, 3'b000, 0, 0, 0};
    vecs[4]  = '{0, 1, 8'hFF, 3'b111, 0, 0, 2'd2, 1, 8'h02, 3'b000, 0, 0, 0};
    vecs[5]  = '{0, 1, 8'hFF, 3'b111, 1, 0, 2'd1, 1, 8'h00, 3'b001, 1, 0, 0};
    vecs[6]  = '{0, 0, 8'h00, 3'b000, 1, 0, 2'd0, 0, 8'h00, 3'b000, 1, 0, 0};
    vecs[7]  = '{0, 0, 8'h00, 3'b000, 1, 0, 2'd0, 0, 8'h00, 3'b000, 1, 0, 0};
    vecs[8]  = '{0, 1, 8'h55, 3'b010, 0, 0, 2'd1, 1, 8'h55, 3'b010, 1, 0, 0};
    vecs[9]  = '{0, 1, 8'h7F, 3'b000, 1, 0, 2'd1, 1, 8'h7F, 3'b000, 1, 0, 0};
    vecs[10] = '{0, 1, 8'h80, 3'b110, 1, 1, 2'd1, 1, 8'h80, 3'b110, 1, 1, 0};
    vecs[11] = '{0, 0, 8'h00, 3'b000, 0, 1, 2'd1, 1, 8'h80, 3'b110, 1, 0, 0};
    vecs[12] = '{0, 1, 8'h00, 3'b000, 0, 0, 2'd2, 1, 8'h80, 3'b110, 0, 0, 1};
    vecs[13] = '{0, 0, 8'h00, 3'b000, 1, 0, 2'd1, 1, 8'h00, 3'b000, 1, 0, 1};
    vecs[14] = '{0, 1, 8'h01, 3'b101, 0, 0, 2'd2, 1, 8'h00, 3'b000, 0, 1, 1};
    vecs[15] = '{1, 0, 8'h00, 3'b000, 1, 0, 2'd0, 0, 8'h00, 3'b000, 0, 0, 0};
    vecs[16] = '{0, 0, 8'h00, 3'b000, 0, 0, 2'd0, 0, 8'h00, 3'b000, 1, 0, 0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] r_res;
    drive(1'b1, 1'b0, 8'h00, 3'b000, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].res, vecs[i].flg, vecs[i].ordy, vecs[i].sclr);
      step();
      chk($sformatf("v%0d_count", i), count, vecs[i].ecnt);
      chk($sformatf("v%0d_out_valid", i), dn_if.valid, vecs[i].eov);
      chk($sformatf("v%0d_out_result", i), dn_if.result, vecs[i].eres);
      chk($sformatf("v%0d_out_flags", i), {dn_if.overflow, dn_if.carry, dn_if.zero}, vecs[i].eflg);
      chk($sformatf("v%0d_in_ready", i), up_if.ready, vecs[i].erdy);
      chk($sformatf("v%0d_sticky_of", i), sticky_of, vecs[i].eso);
      chk($sformatf("v%0d_zero_err", i), zero_err, vecs[i].eze);
    end

    // Fill to two entries, then reset while a pop is requested: nothing survives.
    drive(1'b0, 1'b1, 8'h11, 3'b100, 1'b0, 1'b0); step();
    drive(1'b0, 1'b1, 8'h22, 3'b000, 1'b0, 1'b0); step();
    chk("fill_count", count, 2'd2);
    drive(1'b1, 1'b1, 8'h33, 3'b000, 1'b1, 1'b0); step();
    check_model();
    chk("rst_mid_count", count, 2'd0);
    chk("rst_mid_sticky", sticky_of, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 3'b000, 1'b1, 1'b0); step();
    chk("post_rst_ready", up_if.ready, 1'b1);
    chk("post_rst_valid", dn_if.valid, 1'b0);

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      r_res = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 2) != 0,
            r_res,
            {1'($urandom), 1'($urandom), (r_res == 8'h00) ^ ($urandom_range(0, 9) == 0)},
            1'($urandom),
            $urandom_range(0, 7) == 0);
      step();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
